// File: rtl/pipe_share_pkg.sv
// Shared types and default sizing for the pipeline-sharing arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_share_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int RES_W_DEF     = 32;
  localparam int LATENCY_DEF   = 2;
  localparam int RSP_DEPTH_DEF = 2;

  // Index and counter widths follow the default requester count and FIFO depth.
  localparam int IDX_W = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH_DEF + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // One tag per pipeline stage: which requester owns the result in that slot.
  typedef struct packed {
    logic valid;
    idx_t idx;
  } tag_t;

endpackage

// File: rtl/pipe_share_rsp_fifo.sv
// Per-requester response FIFO with an occupancy count used for credit accounting.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: pop is ignored when empty; push while full cannot happen when credits are honoured.
module pipe_share_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         not_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  assign head      = mem[rd_ptr];

  // Pointer and occupancy update; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (int'(count) == DEPTH)));

endmodule

// File: rtl/pipe_share_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable pipeline among NUM_REQ requesters.
// Latency: grant is combinational; the result reaches the owner's FIFO LATENCY+1 cycles after grant.
// Backpressure: a requester is granted only while FIFO space covers all of its outstanding results.
module pipe_share_arbiter
  import pipe_share_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RES_W     = RES_W_DEF,
  parameter int LATENCY   = LATENCY_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       pipe_input_valid,
  output logic [DATA_W-1:0]          pipe_in_data,
  input  logic                       pipe_output_valid,
  input  logic [RES_W-1:0]           pipe_out_data,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [NUM_REQ*RES_W-1:0]   rsp_data,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic                       err_unexpected
);

  cnt_t               fifo_count [NUM_REQ];
  cnt_t               inflight   [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] push;
  logic               grant_any;
  idx_t               grant_idx;
  idx_t               rr_ptr;
  tag_t               tag_q [LATENCY];
  logic               retire;
  idx_t               ret_idx;

  // A requester may issue only while queued plus in-flight results leave FIFO room.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] &&
                    ((int'(fifo_count[i]) + int'(inflight[i])) < RSP_DEPTH);
    end
  end

  // Pick the first eligible requester at or after rr_ptr, wrapping; nothing in reset.
  always_comb begin
    int c;
    grant_any = 1'b0;
    grant_idx = '0;
    c         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && eligible[c]) begin
        grant_any = 1'b1;
        grant_idx = idx_t'(c);
      end
    end
    if (rst) grant_any = 1'b0;
  end

  // One-hot grant vector toward the requesters.
  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign pipe_input_valid = grant_any;
  assign pipe_in_data     = grant_any ? req_data[int'(grant_idx)*DATA_W +: DATA_W] : '0;

  // The last tag stage lines up with the pipeline's output.
  assign retire  = pipe_output_valid && tag_q[LATENCY-1].valid;
  assign ret_idx = tag_q[LATENCY-1].idx;

  // Steer a retiring result into its owner's FIFO; untagged results are dropped.
  always_comb begin
    push = '0;
    if (retire) push[ret_idx] = 1'b1;
  end

  // Round-robin pointer, owner tag shift register, and sticky tag/output disagreement flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      err_unexpected <= 1'b0;
      for (int s = 0; s < LATENCY; s++) begin
        tag_q[s].valid <= 1'b0;
        tag_q[s].idx   <= '0;
      end
    end else begin
      if (grant_any) rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      tag_q[0].valid <= grant_any;
      tag_q[0].idx   <= grant_idx;
      for (int s = 1; s < LATENCY; s++) tag_q[s] <= tag_q[s-1];
      if (pipe_output_valid != tag_q[LATENCY-1].valid) err_unexpected <= 1'b1;
    end
  end

  // Outstanding results per requester: grant adds one, retire removes one.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst)                          inflight[i] <= '0;
      else if (req_ready[i] && !push[i]) inflight[i] <= inflight[i] + 1'b1;
      else if (!req_ready[i] && push[i]) inflight[i] <= inflight[i] - 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    pipe_share_rsp_fifo #(
      .WIDTH (RES_W),
      .DEPTH (RSP_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .push_data (pipe_out_data),
      .pop       (rsp_ready[g]),
      .head      (rsp_data[g*RES_W +: RES_W]),
      .count     (fifo_count[g]),
      .not_empty (rsp_valid[g])
    );
  end

endmodule
